// File: rtl/fc_2nd_mac_engine_pkg.sv
// Shared constants for the second fully-connected layer.
// Holds the Q8.8 number format, the lane and accumulator widths,
// the output saturation limits and the engine state encoding.
package fc_2nd_mac_engine_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int LANES     = 5;
  localparam int ACC_WIDTH = 40;

  localparam logic signed [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MAC,
    ST_BIAS,
    ST_OUT
  } state_t;

endpackage

// File: rtl/fc_dot5.sv
// Combinational signed dot product across a small set of lanes.
// Each lane multiplies a signed data word by a signed weight word to a
// full-precision product, and the products are summed with enough
// headroom that the sum can never wrap.
// Ports:
//   data   - Lanes packed signed data words, lane 0 in the LSBs
//   weight - Lanes packed signed weight words, lane 0 in the LSBs
//   sum    - signed sum of the Lanes products
module fc_dot5
  import fc_2nd_mac_engine_pkg::*;
#(
  parameter int  Bit_width = BIT_WIDTH,
  parameter int  Lanes     = LANES,
  localparam int Sum_width = 2*Bit_width + $clog2(Lanes)
) (
  input  logic        [Lanes*Bit_width-1:0] data,
  input  logic        [Lanes*Bit_width-1:0] weight,
  output logic signed [Sum_width-1:0]       sum
);

  logic signed [2*Bit_width-1:0] prod [Lanes];

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    assign prod[i] = $signed(data[i*Bit_width +: Bit_width])
                   * $signed(weight[i*Bit_width +: Bit_width]);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < Lanes; i++) begin
      sum = sum + Sum_width'(prod[i]);
    end
  end

endmodule

// File: rtl/fc_2nd_mac_engine.sv
// Compute engine for the second fully-connected layer.
// For each output neuron it walks the data RAM read window over the whole
// input vector, accumulates the lane products chunk by chunk, adds the
// neuron bias, rescales back to Q8.8, saturates, optionally clamps
// negatives to zero, and emits one result with a valid strobe.
//
//   state | meaning
//   IDLE  | waiting for start
//   READ  | addresses for current chunk presented to RAM/ROMs
//   MAC   | RAM/ROM words valid, accumulate the chunk dot product
//   BIAS  | add bias, rescale, saturate, register result
//   OUT   | result strobed; advance neuron or finish the pass
//
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   start        - begin a pass (only honoured in IDLE)
//   busy, done   - pass in progress / one-cycle pass-complete pulse
//   Read_Enable  - data RAM read request, Read_Width its base address
//   data_in      - data RAM window, Lanes packed signed words
//   weight_addr  - weight ROM address, weight_in its Lanes packed weights
//   bias_addr    - bias ROM address, bias_in the signed bias
//   out_valid    - result strobe with out_index and out_data
module fc_2nd_mac_engine
  import fc_2nd_mac_engine_pkg::*;
#(
  parameter int  Bit_width = BIT_WIDTH,
  parameter int  In_Len    = 16,
  parameter int  Out_Len   = 8,
  parameter int  Lanes     = LANES,
  parameter int  Frac_bits = FRAC_BITS,
  parameter int  Acc_width = ACC_WIDTH,
  parameter int  Use_ReLU  = 1,
  localparam int Chunks    = (In_Len + Lanes - 1) / Lanes,
  localparam int Rd_aw     = $clog2(In_Len),
  localparam int W_aw      = $clog2(Out_Len*Chunks),
  localparam int N_aw      = $clog2(Out_Len),
  localparam int C_aw      = (Chunks > 1) ? $clog2(Chunks) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       Read_Enable,
  output logic [Rd_aw-1:0]           Read_Width,
  input  logic [Lanes*Bit_width-1:0] data_in,
  output logic [W_aw-1:0]            weight_addr,
  input  logic [Lanes*Bit_width-1:0] weight_in,
  output logic [N_aw-1:0]            bias_addr,
  input  logic [Bit_width-1:0]       bias_in,
  output logic                       out_valid,
  output logic [N_aw-1:0]            out_index,
  output logic [Bit_width-1:0]       out_data
);

  localparam int Dot_width = 2*Bit_width + $clog2(Lanes);
  localparam logic signed [Acc_width-1:0] Sat_hi = Acc_width'(SAT_MAX);
  localparam logic signed [Acc_width-1:0] Sat_lo = Acc_width'(SAT_MIN);

  state_t state_q, state_d;

  logic [N_aw-1:0] neuron_q, neuron_d;
  logic [C_aw-1:0] chunk_q, chunk_d;
  logic            last_chunk, last_neuron;

  logic signed [Acc_width-1:0] acc_q;
  logic signed [Acc_width-1:0] acc_biased;
  logic signed [Acc_width-1:0] acc_shifted;
  logic signed [Dot_width-1:0] dot_sum;
  logic        [Bit_width-1:0] result;

  fc_dot5 #(
    .Bit_width (Bit_width),
    .Lanes     (Lanes)
  ) u_dot5 (
    .data   (data_in),
    .weight (weight_in),
    .sum    (dot_sum)
  );

  assign last_chunk  = (chunk_q == C_aw'(Chunks - 1));
  assign last_neuron = (neuron_q == N_aw'(Out_Len - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    neuron_d    = neuron_q;
    chunk_d     = chunk_q;
    busy        = (state_q != ST_IDLE);
    Read_Enable = (state_q == ST_READ);
    out_valid   = (state_q == ST_OUT);
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          neuron_d = '0;
          chunk_d  = '0;
        end
      end
      ST_READ: state_d = ST_MAC;
      ST_MAC: begin
        if (last_chunk) begin
          state_d = ST_BIAS;
        end else begin
          state_d = ST_READ;
          chunk_d = chunk_q + 1'b1;
        end
      end
      ST_BIAS: state_d = ST_OUT;
      ST_OUT: begin
        chunk_d = '0;
        if (last_neuron) begin
          done     = 1'b1;
          neuron_d = '0;
          state_d  = ST_IDLE;
        end else begin
          neuron_d = neuron_q + 1'b1;
          state_d  = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bias is aligned to the Q16.16 product scale before the rescale shift.
  assign acc_biased  = acc_q + (Acc_width'($signed(bias_in)) <<< Frac_bits);
  assign acc_shifted = acc_biased >>> Frac_bits;

  always_comb begin
    if (acc_shifted > Sat_hi) begin
      result = SAT_MAX;
    end else if (acc_shifted < Sat_lo) begin
      result = SAT_MIN;
    end else begin
      result = acc_shifted[Bit_width-1:0];
    end
    if ((Use_ReLU != 0) && result[Bit_width-1]) begin
      result = '0;
    end
  end

  // Addresses are registered on entry to READ so the RAM/ROMs see them for
  // the whole READ cycle and they hold steady outside it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      neuron_q    <= '0;
      chunk_q     <= '0;
      acc_q       <= '0;
      Read_Width  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
      out_index   <= '0;
      out_data    <= '0;
    end else begin
      neuron_q <= neuron_d;
      chunk_q  <= chunk_d;
      if (state_d == ST_READ) begin
        Read_Width  <= Rd_aw'(chunk_d * Lanes);
        weight_addr <= W_aw'(neuron_d * Chunks + chunk_d);
        bias_addr   <= neuron_d;
      end
      case (state_q)
        ST_IDLE: if (start) acc_q <= '0;
        ST_MAC:  acc_q <= acc_q + Acc_width'(dot_sum);
        ST_BIAS: begin
          acc_q     <= acc_biased;
          out_data  <= result;
          out_index <= neuron_q;
        end
        ST_OUT:  acc_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_2nd_mac_engine.sv
// Bench for fc_2nd_mac_engine. Two engines share stimulus, one with ReLU
// and one without. Memories are modelled around each engine; every
// result is compared with a plain-arithmetic dot product over the
// input vector, and the cycle-level schedule follows the fixed
// 10-cycle-per-neuron timeline.
module tb_fc_2nd_mac_engine;

  localparam int BW         = 16;
  localparam int IN_LEN     = 16;
  localparam int OUT_LEN    = 8;
  localparam int LANES      = 5;
  localparam int CHUNKS     = 4;
  localparam int NEURON_CYC = 2*CHUNKS + 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [BW-1:0]       dmem [IN_LEN];
  logic [LANES*BW-1:0] wrom [OUT_LEN*CHUNKS];
  logic [BW-1:0]       brom [OUT_LEN];

  logic          busy      [2];
  logic          done      [2];
  logic          read_en   [2];
  logic          out_valid [2];
  logic [3:0]    rd_width  [2];
  logic [4:0]    w_addr    [2];
  logic [2:0]    b_addr    [2];
  logic [2:0]    out_index [2];
  logic [BW-1:0] out_data  [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [LANES*BW-1:0] d_in;
    logic [LANES*BW-1:0] w_in;
    logic [BW-1:0]       b_in;

    fc_2nd_mac_engine #(.Use_ReLU(g == 0 ? 1 : 0)) u_dut (
      .CLK         (clk),
      .RST         (rst),
      .start       (start),
      .busy        (busy[g]),
      .done        (done[g]),
      .Read_Enable (read_en[g]),
      .Read_Width  (rd_width[g]),
      .data_in     (d_in),
      .weight_addr (w_addr[g]),
      .weight_in   (w_in),
      .bias_addr   (b_addr[g]),
      .bias_in     (b_in),
      .out_valid   (out_valid[g]),
      .out_index   (out_index[g]),
      .out_data    (out_data[g])
    );

    // Data RAM: latches the 5-wide window on negedge, zero past the end.
    always @(negedge clk) begin
      if (read_en[g]) begin
        for (int l = 0; l < LANES; l++) begin
          if (int'(rd_width[g]) + l < IN_LEN)
            d_in[l*BW +: BW] <= dmem[int'(rd_width[g]) + l];
          else
            d_in[l*BW +: BW] <= '0;
        end
      end
    end

    always @(posedge clk) begin
      w_in <= wrom[w_addr[g]];
      b_in <= brom[b_addr[g]];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_outputs(input int g);
    return 64'({busy[g], done[g], read_en[g], rd_width[g], w_addr[g], b_addr[g],
                out_valid[g], out_index[g], out_data[g]});
  endfunction

  // Reference: full dot product over the input vector, bias, rescale,
  // saturate, optional ReLU.
  function automatic logic [BW-1:0] model(input int n, input bit relu);
    longint acc;
    logic [LANES*BW-1:0] word;
    logic signed [BW-1:0] w;
    logic signed [BW-1:0] d;
    logic signed [BW-1:0] b;
    acc = 0;
    for (int i = 0; i < IN_LEN; i++) begin
      word = wrom[n*CHUNKS + i/LANES];
      w    = word[(i%LANES)*BW +: BW];
      d    = dmem[i];
      acc += longint'(d) * longint'(w);
    end
    b   = brom[n];
    acc += longint'(b) * 256;
    acc = acc >>> 8;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] pick(input int kind, input int which);
    case (kind)
      0: return 16'h0100;
      1: return (which == 0) ? 16'h0100 : (which == 1) ? 16'hFF00 : 16'h0200;
      2: return (which == 2) ? 16'($urandom) : 16'h7FFF;
      3: return (which == 0) ? 16'h7FFF : (which == 1) ? 16'h8000 : 16'h0000;
      4: return (which == 2) ? 16'($urandom_range(0, 8191) - 4096)
                             : 16'($urandom_range(0, 1023) - 512);
      default: return 16'($urandom);
    endcase
  endfunction

  // kind 0: 1.0 x 1.0; 1: 1.0 x -1.0 bias 2.0; 2: +saturation;
  // 3: max x min; 4: small random; 5: full-range random
  task automatic fill(input int kind);
    for (int i = 0; i < IN_LEN; i++) dmem[i] = pick(kind, 0);
    for (int a = 0; a < OUT_LEN*CHUNKS; a++)
      for (int l = 0; l < LANES; l++) wrom[a][l*BW +: BW] = pick(kind, 1);
    for (int n = 0; n < OUT_LEN; n++) brom[n] = pick(kind, 2);
  endtask

  // mode 0: plain pass; 1: extra start pulses mid-pass and on the done
  // cycle; 2: reset during neuron 3 MAC.
  task automatic run_pass(input int mode);
    int  n_done;
    int  last_cyc;
    int  nrn;
    int  ph;
    bit  in_pass;
    bit  exp_re;
    bit  exp_ov;
    n_done   = 0;
    last_cyc = (mode == 2) ? 33 : OUT_LEN*NEURON_CYC + 2;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      if (mode == 2 && cyc == 33) begin
        for (int g = 0; g < 2; g++) check("reset_mid_pass", pack_outputs(g), 64'd0);
        rst = 1'b0;
      end else begin
        nrn     = (cyc - 1) / NEURON_CYC;
        ph      = (cyc - 1) % NEURON_CYC;
        in_pass = (cyc <= OUT_LEN*NEURON_CYC);
        exp_re  = in_pass && (ph < 2*CHUNKS) && (ph % 2 == 0);
        exp_ov  = in_pass && (ph == NEURON_CYC - 1);
        for (int g = 0; g < 2; g++) begin
          check("busy", 64'(busy[g]), 64'(in_pass));
          check("read_enable", 64'(read_en[g]), 64'(exp_re));
          check("out_valid", 64'(out_valid[g]), 64'(exp_ov));
          check("done", 64'(done[g]), 64'(exp_ov && nrn == OUT_LEN - 1));
          if (exp_re) begin
            check("read_width", 64'(rd_width[g]), 64'((ph/2) * LANES));
            check("weight_addr", 64'(w_addr[g]), 64'(nrn*CHUNKS + ph/2));
            check("bias_addr", 64'(b_addr[g]), 64'(nrn));
          end
          if (exp_ov) begin
            check("out_index", 64'(out_index[g]), 64'(nrn));
            check(g == 0 ? "out_data_relu" : "out_data_lin",
                  64'(out_data[g]), 64'(model(nrn, g == 0)));
          end
          if (done[g]) n_done++;
        end
      end
      start = (mode == 1) && (cyc == 25 || cyc == 80);
      if (mode == 2 && cyc == 32) rst = 1'b1;
    end
    start = 1'b0;
    if (mode != 2) check("done_count", 64'(n_done), 64'd2);
  endtask

  initial begin
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("reset_state", pack_outputs(g), 64'd0);
    rst = 1'b0;

    fill(0); run_pass(0);
    fill(1); run_pass(0);
    fill(2); run_pass(0);
    fill(3); run_pass(0);
    repeat (3) begin
      fill(4); run_pass(0);
    end
    fill(5); run_pass(0);
    fill(4); run_pass(1);
    fill(5); run_pass(2);
    fill(4); run_pass(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_2nd_mac_engine.md
Name: fc_2nd_mac_engine

Overview:
- Compute engine for the second fully-connected layer; sits directly downstream of the 16-entry FC-2nd data RAM.
- Sweeps the RAM's 5-wide read window over all inputs for each output neuron and accumulates 5 products per chunk.
- Adds the neuron bias, rescales, saturates and optionally applies ReLU.
- Emits one result per neuron with a valid strobe to the next layer's buffer.

Parameters:
- Bit_width, 16, data/weight/bias/result width, signed Q8.8
- In_Len, 16, input vector length (matches data RAM depth)
- Out_Len, 8, number of output neurons
- Lanes, 5, parallel read/MAC lanes
- Frac_bits, 8, fractional bits of the Q format
- Acc_width, 40, accumulator width
- Use_ReLU, 1, 1 = clamp negative results to 0

Ports:
- CLK  in  1  clock; posedge logic
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a layer pass when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last neuron result
- Read_Enable  out  1  read request to data RAM
- Read_Width  out  4  data RAM base read address (chunk index × 5)
- data_in  in  Lanes*Bit_width  data RAM outputs 0..4 packed, lane 0 in LSBs, signed
- weight_addr  out  clog2(Out_Len*ceil(In_Len/Lanes))  weight ROM word address = neuron*Chunks + chunk
- weight_in  in  Lanes*Bit_width  5 packed signed weights; 1-cycle ROM latency
- bias_addr  out  clog2(Out_Len)  bias ROM address = current neuron
- bias_in  in  Bit_width  signed bias; 1-cycle latency
- out_valid  out  1  one-cycle strobe; result and index valid
- out_index  out  clog2(Out_Len)  neuron number of result
- out_data  out  Bit_width  signed result

Behaviour:
- Chunks = ceil(In_Len/Lanes) = 4 with the defaults; chunk bases 0, 5, 10, 15.
- Data RAM zero-pads lanes past index 15. The engine needs no masking and multiplies all 5 lanes every chunk.
- Data RAM latches on negedge, so the address issued at posedge k is sampled at posedge k+1. Weight and bias ROMs are treated the same way (1-cycle).
- FSM states: IDLE, READ, MAC, BIAS, OUT.
  - IDLE: on start → READ; neuron=0, chunk=0, acc=0.
  - READ: Read_Enable=1, Read_Width=chunk*5, weight_addr=neuron*Chunks+chunk, bias_addr=neuron → MAC.
  - MAC: acc += sign-extended sum of data_in[i]*weight_in[i], i=0..4. Each product is a 32-bit Q16.16 value.
    - If chunk < Chunks-1: chunk++ → READ.
    - Otherwise → BIAS.
  - BIAS: acc += sign-extend(bias_in) << Frac_bits.
    - sum = acc >>> Frac_bits (arithmetic).
    - Saturate to [-32768, 32767].
    - If Use_ReLU, negative → 0.
    - Register into out_data → OUT.
  - OUT: out_valid=1, out_index=neuron.
    - If neuron == Out_Len-1: done=1 → IDLE.
    - Otherwise: neuron++, chunk=0, acc=0 → READ.
- Latency: 2*Chunks+2 cycles per neuron (10 with defaults). First out_valid 10 cycles after the accepted start; done coincides with the last out_valid.
- Read_Enable is high only in READ. Address outputs hold their last value otherwise.
- start while busy is ignored. start in the same cycle as done's return to IDLE is not accepted; start must arrive in IDLE.
- There is no back-pressure on the output; the consumer must accept every out_valid.
- Reset mid-pass: next cycle state=IDLE, acc=0, counters=0, pass abandoned, no done.
- Reset values: busy=0, done=0, Read_Enable=0, Read_Width=0, weight_addr=0, bias_addr=0, out_valid=0, out_index=0, out_data=0.
- Accumulator overflow is not possible for Q8.8 with In_Len ≤ 256 at 40 bits. Saturation happens only at output.

Decomposition:
- Shared package (constants):
  - Q format: Bit_width, Frac_bits
  - Lanes, Acc_width
  - FSM state encoding
  - SAT_MAX/SAT_MIN constants
- Sub-module fc_dot5: combinational 5-lane signed multiply + adder tree producing a 35-bit sum, reusable by other FC stages. Engine owns the FSM, counters and accumulator.

Test Plan:
- All data=0x0100 (1.0), all weights=0x0100, bias=0, In_Len=16 → each neuron out_data=0x1000 (16.0). Lanes past 15 are zero so the sum is not 20. 8 out_valid pulses 10 cycles apart; done with the 8th.
- Data=0x0100, weights=0xFF00 (-1.0), bias=0x0200, Use_ReLU=1 → out_data=0 for every neuron. Same case with Use_ReLU=0 → 0xF200 (-14.0).
- Data=0x7FFF, weights=0x7FFF → positive saturation, out_data=0x7FFF. Weights=0x8000, Use_ReLU=0 → out_data=0x8001 or saturates to 0x8000 per the exact sum; checked against the reference model.
- Address trace: neuron 2 → Read_Width sequence 0,5,10,15; weight_addr 8,9,10,11; bias_addr 2. Read_Enable high exactly 4 cycles per neuron.
- start pulsed while busy mid-pass → ignored, result sequence unchanged, exactly one done.
- RST asserted during neuron 3 MAC → next cycle all outputs at reset values. A new start yields a full clean pass from neuron 0.
